// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks.
//   uart_state_e : transmitter FSM states
//   START_BITS   : start bits per frame
//   DATA_BITS    : data bits per frame
//   calc_div     : clocks per bit, rounded to nearest, from clock and baud rates
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam int unsigned START_BITS = 1;
  localparam int unsigned DATA_BITS  = 8;

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered status flags.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   push_i, wdata_i   : write request and data (ignored while full)
//   pop_i, rdata_o    : read request (ignored while empty); rdata_o shows the head entry
//   full_o, empty_o   : occupancy flags, valid for the state after the current edge
//   count_o           : occupancy, 0..Depth
module uart_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned Aw = $clog2(Depth);
  localparam logic [Aw:0] DepthCnt = (Aw + 1)'(Depth);

  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : gen_bad_depth
    $error("uart_sync_fifo: Depth must be a power of two and at least 2");
  end

  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0]    wr_ptr_q, wr_ptr_d;
  logic [Aw-1:0]    rd_ptr_q, rd_ptr_d;
  logic [Aw:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  // A push while full is dropped even when a pop frees a slot in the same cycle.
  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DepthCnt);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: bytes written into a FIFO are sent back to back as
// 1 start bit, 8 data bits LSB first, optional parity and 1 or 2 stop bits.
//   clk, rst        : clock, asynchronous active-high reset
//   wr_en, wr_data  : push a byte into the FIFO (dropped while full)
//   full, empty     : FIFO occupancy flags
//   count           : FIFO occupancy
//   TxD             : serial line, idles high
//   busy            : frame in progress or bytes still buffered
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned ClkFrequency = 25000000,
  parameter int unsigned Baud         = 115200,
  parameter int unsigned FifoDepth    = 16,
  parameter int unsigned ParityEn     = 0,
  parameter int unsigned ParityOdd    = 0,
  parameter int unsigned StopBits     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [7:0]                   wr_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(FifoDepth):0]   count,
  output logic                         TxD,
  output logic                         busy
);

  localparam int unsigned Div         = calc_div(ClkFrequency, Baud);
  localparam int unsigned StartCycles = START_BITS * Div;
  localparam int unsigned StopCycles  = StopBits * Div;
  localparam int unsigned MaxCycles   = (StopCycles > StartCycles) ? StopCycles : StartCycles;
  localparam int unsigned CntW        = $clog2(MaxCycles);
  localparam int unsigned IdxW        = $clog2(DATA_BITS);

  localparam logic [CntW-1:0] DivM1   = CntW'(Div - 1);
  localparam logic [CntW-1:0] StartM1 = CntW'(StartCycles - 1);
  localparam logic [CntW-1:0] StopM1  = CntW'(StopCycles - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);

  if (Div < 2) begin : gen_bad_div
    $error("uart_tx_buffered: clocks per bit must be at least 2");
  end
  if (StopBits != 1 && StopBits != 2) begin : gen_bad_stop
    $error("uart_tx_buffered: StopBits must be 1 or 2");
  end

  uart_state_e          state_q, state_d;
  logic [CntW-1:0]      baud_q, baud_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 load;
  logic                 pop;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_empty;

  uart_sync_fifo #(
    .Width (DATA_BITS),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (wr_en),
    .wdata_i (wr_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  // Next-state logic. The baud counter counts down to zero within each bit and
  // only runs outside idle, so every frame begins with a full start bit.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    load    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) load = 1'b1;
      end
      StStart: begin
        if (baud_q == '0) begin
          state_d = StData;
          idx_d   = '0;
          baud_d  = DivM1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StData: begin
        if (baud_q == '0) begin
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (idx_q == LastIdx) begin
            if (ParityEn != 0) begin
              state_d = StParity;
              baud_d  = DivM1;
            end else begin
              state_d = StStop;
              baud_d  = StopM1;
            end
          end else begin
            idx_d  = idx_q + 1'b1;
            baud_d = DivM1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StParity: begin
        if (baud_q == '0) begin
          state_d = StStop;
          baud_d  = StopM1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StStop: begin
        if (baud_q == '0) begin
          // Chain straight into the next start bit when more data is waiting.
          if (!fifo_empty) load = 1'b1;
          else             state_d = StIdle;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      state_d = StStart;
      baud_d  = StartM1;
      shift_d = fifo_rdata;
      // Parity is captured at load time since the shifter destroys the byte.
      par_d   = (^fifo_rdata) ^ (ParityOdd != 0);
    end
  end

  assign pop = load;

  // Line and busy are registered from the current state, so TxD lags the state
  // register by one cycle and busy drops together with the end of the last frame.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_q[0];
      StParity: tx_d = par_q;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_q != StIdle) | ~fifo_empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign empty = fifo_empty;
  assign TxD   = tx_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered. Five instances cover the default
// 217-clock bit time, a fast 4-clock bit time, both parity senses and one stop bit.
module tb_uart_tx_buffered;

  localparam int NDut = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NDut-1:0]  wr_en = '0;
  logic [7:0]       wr_data = '0;
  logic [NDut-1:0]  tx, busy_w, full_w, empty_w;
  logic [4:0]       cnt_w [NDut];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    localparam int unsigned Clk  = (g == 0) ? 25000000 : 1000000;
    localparam int unsigned Bd   = (g == 0) ? 115200 : 250000;
    localparam int unsigned PEn  = (g == 2 || g == 3) ? 1 : 0;
    localparam int unsigned POdd = (g == 3) ? 1 : 0;
    localparam int unsigned Stop = (g == 4) ? 1 : 2;
    uart_tx_buffered #(
      .ClkFrequency (Clk),
      .Baud         (Bd),
      .FifoDepth    (16),
      .ParityEn     (PEn),
      .ParityOdd    (POdd),
      .StopBits     (Stop)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[g]),
      .wr_data (wr_data),
      .full    (full_w[g]),
      .empty   (empty_w[g]),
      .count   (cnt_w[g]),
      .TxD     (tx[g]),
      .busy    (busy_w[g])
    );
  end

  // Expected line parameters per instance.
  function automatic int exp_div(input int k);  return (k == 0) ? 217 : 4;            endfunction
  function automatic int exp_par(input int k);  return (k == 2 || k == 3) ? 1 : 0;    endfunction
  function automatic int exp_odd(input int k);  return (k == 3) ? 1 : 0;              endfunction
  function automatic int exp_stop(input int k); return (k == 4) ? 1 : 2;              endfunction
  function automatic int frame_len(input int k);
    return (1 + 8 + exp_par(k) + exp_stop(k)) * exp_div(k);
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Scoreboard and monitor state.
  logic [7:0] exp_q [$];
  int         start_q [$];
  int         sel = 0;
  bit         mon_on = 1'b1;
  logic       last_par = 1'b0;
  int         wr_edge = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called on the first sampled cycle of a start bit; checks every cycle of the frame.
  task automatic rx_frame(input int k);
    int         d;
    int         bad;
    logic [7:0] b;
    logic       p;
    logic       odd;
    d   = exp_div(k);
    bad = 0;
    b   = '0;
    p   = 1'b0;
    odd = (exp_odd(k) != 0);
    start_q.push_back(cyc);
    for (int c = 0; c < d; c++) begin
      if (c > 0) step();
      if (tx[k] !== 1'b0) bad++;
    end
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < d; c++) begin
        step();
        if (c == 0) b[i] = tx[k];
        else if (tx[k] !== b[i]) bad++;
      end
    end
    if (exp_par(k) != 0) begin
      for (int c = 0; c < d; c++) begin
        step();
        if (c == 0) p = tx[k];
        else if (tx[k] !== p) bad++;
      end
      last_par = p;
      check_val("parity_bit", 32'(p), 32'((^b) ^ odd));
    end
    for (int c = 0; c < exp_stop(k) * d; c++) begin
      step();
      if (tx[k] !== 1'b1) bad++;
    end
    check_val("frame_shape", bad, 0);
    if (exp_q.size() == 0) check_val("unexpected_frame", 32'(b), 32'hffff_ffff);
    else                   check_val("rx_byte", 32'(b), 32'(exp_q.pop_front()));
  endtask

  initial begin : monitor
    forever begin
      step();
      if (mon_on && tx[sel] === 1'b0) rx_frame(sel);
    end
  end

  task automatic drive(input int k, input logic [7:0] d, input bit accept);
    @(negedge clk);
    wr_en    = '0;
    wr_en[k] = 1'b1;
    wr_data  = d;
    if (accept) exp_q.push_back(d);
    wr_edge = cyc + 1;
  endtask

  task automatic drive_end();
    @(negedge clk);
    wr_en = '0;
  endtask

  task automatic wait_busy_low(input int k, input int budget, output int fall);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (busy_w[k] !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val("busy_fall_in_budget", 32'(n < budget), 1);
    fall = cyc;
  endtask

  initial begin : main
    int fall;
    int e0;
    int n;
    int bad;
    logic [7:0] burst [3];
    burst[0] = 8'h00;
    burst[1] = 8'hff;
    burst[2] = 8'ha5;

    // Reset state.
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDut; k++) begin
      check_val("rst_txd", 32'(tx[k]), 1);
      check_val("rst_busy", 32'(busy_w[k]), 0);
      check_val("rst_full", 32'(full_w[k]), 0);
      check_val("rst_empty", 32'(empty_w[k]), 1);
      check_val("rst_count", 32'(cnt_w[k]), 0);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single byte on the default instance.
    sel = 0;
    start_q.delete();
    drive(0, 8'h55, 1'b1);
    drive_end();
    wait_busy_low(0, 5000, fall);
    check_val("single_frames", start_q.size(), 1);
    check_val("single_start_edge", start_q[0], wr_edge + 2);
    check_val("single_busy_fall", fall - start_q[0], 2387);
    check_val("single_drained", exp_q.size(), 0);

    // Burst of three back-to-back bytes.
    start_q.delete();
    for (int i = 0; i < 3; i++) drive(0, burst[i], 1'b1);
    drive_end();
    wait_busy_low(0, 10000, fall);
    check_val("burst_frames", start_q.size(), 3);
    check_val("burst_gap_0_1", start_q[1] - start_q[0], 2387);
    check_val("burst_gap_1_2", start_q[2] - start_q[1], 2387);
    check_val("burst_busy_span", fall - start_q[0], 3 * 2387);
    check_val("burst_drained", exp_q.size(), 0);

    // Overflow: 18 consecutive writes, the last one is dropped.
    sel = 1;
    start_q.delete();
    for (int i = 0; i < 18; i++) drive(1, 8'(i), (i < 17));
    drive_end();
    check_val("ovf_count", 32'(cnt_w[1]), 16);
    check_val("ovf_full", 32'(full_w[1]), 1);
    check_val("ovf_empty", 32'(empty_w[1]), 0);
    wait_busy_low(1, 2000, fall);
    check_val("ovf_frames", start_q.size(), 17);
    check_val("ovf_drained", exp_q.size(), 0);

    // Parity and stop-bit variants with byte 0x07.
    for (int k = 2; k < NDut; k++) begin
      sel = k;
      start_q.delete();
      drive(k, 8'h07, 1'b1);
      drive_end();
      wait_busy_low(k, 500, fall);
      check_val("variant_frames", start_q.size(), 1);
      check_val("variant_frame_len", fall - start_q[0], frame_len(k));
      if (k == 2) check_val("even_parity_0x07", 32'(last_par), 1);
      if (k == 3) check_val("odd_parity_0x07", 32'(last_par), 0);
    end
    check_val("stop1_len_is_10_div", frame_len(4), 40);

    // Simultaneous push and pop on the final stop cycle.
    sel = 1;
    start_q.delete();
    for (int i = 0; i < 6; i++) drive(1, 8'(8'h10 + i), 1'b1);
    drive_end();
    check_val("pp_count_before", 32'(cnt_w[1]), 5);
    n = 0;
    while (start_q.size() < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("pp_first_start", start_q.size(), 1);
    e0 = start_q[0];
    // The pop edge is one cycle before the next start bit appears on the line.
    while (cyc < e0 + frame_len(1) - 2) @(negedge clk);
    check_val("pp_count_pre", 32'(cnt_w[1]), 5);
    wr_en[1] = 1'b1;
    wr_data  = 8'he7;
    exp_q.push_back(8'he7);
    @(negedge clk);
    wr_en = '0;
    check_val("pp_count_after", 32'(cnt_w[1]), 5);
    wait_busy_low(1, 1000, fall);
    check_val("pp_frames", start_q.size(), 7);
    for (int i = 0; i + 1 < start_q.size(); i++)
      check_val("pp_contiguous", start_q[i + 1] - start_q[i], frame_len(1));
    check_val("pp_drained", exp_q.size(), 0);

    // Reset during data bit 3 with four bytes queued behind the active one.
    mon_on = 1'b0;
    drive(1, 8'h00, 1'b0);
    drive(1, 8'h11, 1'b0);
    drive(1, 8'h22, 1'b0);
    drive(1, 8'h33, 1'b0);
    drive(1, 8'h44, 1'b0);
    drive_end();
    n = 0;
    while (tx[1] !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("rstmid_start_seen", 32'(n < 50), 1);
    e0 = cyc;
    while (cyc < e0 + 17) @(negedge clk);
    check_val("rstmid_pre_txd", 32'(tx[1]), 0);
    check_val("rstmid_pre_count", 32'(cnt_w[1]), 4);
    #2;
    rst = 1'b1;
    #1;
    check_val("rstmid_txd", 32'(tx[1]), 1);
    check_val("rstmid_count", 32'(cnt_w[1]), 0);
    check_val("rstmid_empty", 32'(empty_w[1]), 1);
    check_val("rstmid_busy", 32'(busy_w[1]), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx[1] !== 1'b1 || busy_w[1] !== 1'b0) bad++;
    end
    check_val("rstmid_quiet_line", bad, 0);
    mon_on = 1'b1;
    start_q.delete();
    drive(1, 8'h3c, 1'b1);
    drive_end();
    wait_busy_low(1, 200, fall);
    check_val("rstmid_new_frames", start_q.size(), 1);
    check_val("rstmid_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got time limit reached, expected summary before it");
    $fatal(1, "simulation time limit reached");
  end

endmodule
